// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared types and constants for the RAM access controller.
package ram_ctrl_pkg;

  localparam int RAM_ADDR_W = 5;
  localparam int RAM_DATA_W = 4;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_SCAN  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_CAP,
    RD_DONE,
    CLEAR,
    SCAN_IDLE
  } state_e;

endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running 0..DIV-1 counter while enabled; tick is high
// during the terminal-count cycle. The count holds when disabled.
module tick_divider #(
  parameter int DIV = 25000000
) (
  input  logic clock,
  input  logic resetn,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TERM);

  // next count: wrap at terminal count, hold while disabled
  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // count register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: command sequencer in front of the single-port RAM.
// Handles read / write / clear-all over a valid/ready handshake and returns
// read data with its address. Auto-scan (op 11) is built only when the
// macro RAM_AUTOSCAN_EN is defined; otherwise op 11 is a one-cycle no-op.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DATA_W   = RAM_DATA_W,
  parameter int SCAN_DIV = 25000000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              scanning
);

  // A scan read needs RD_ADDR/RD_CAP/RD_DONE to fit between ticks.
  if (SCAN_DIV < 3) begin : g_bad_scan_div
    $error("ram_access_ctrl: SCAN_DIV must be at least 3");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              accept;

`ifdef RAM_AUTOSCAN_EN
  logic              scanning_q, scanning_d;
  logic              pend_q, pend_d;     // tick seen while busy, not yet served
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic              tick;

  tick_divider #(.DIV(SCAN_DIV)) u_tick_divider (
    .clock  (clock),
    .resetn (resetn),
    .en     (scanning_q),
    .tick   (tick)
  );
`endif

  assign cmd_ready = (state_q == IDLE) || (state_q == SCAN_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // next-state and RAM pin sequencing; RAM pins are registered and hold
  // their last value, only wren returns to 0 outside WRITE/CLEAR
  always_comb begin
    state_d       = state_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    rd_valid_d    = 1'b0;
    rd_addr_d     = rd_addr_q;
    rd_data_d     = rd_data_q;
`ifdef RAM_AUTOSCAN_EN
    scanning_d    = scanning_q;
    scan_addr_d   = scan_addr_q;
    pend_d        = pend_q || tick;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_READ: begin
              state_d       = RD_ADDR;
              ram_address_d = cmd_addr;
            end
            OP_WRITE: begin
              state_d       = WRITE;
              ram_address_d = cmd_addr;
              ram_data_d    = cmd_data;
              ram_wren_d    = 1'b1;
            end
            OP_CLEAR: begin
              state_d       = CLEAR;
              ram_address_d = '0;
              ram_data_d    = '0;
              ram_wren_d    = 1'b1;
            end
            default: begin
`ifdef RAM_AUTOSCAN_EN
              state_d    = SCAN_IDLE;
              scanning_d = 1'b1;
`endif
            end
          endcase
        end
      end
      WRITE: begin
        state_d = IDLE;
`ifdef RAM_AUTOSCAN_EN
        if (scanning_q) begin
          state_d = SCAN_IDLE;
          // a tick that landed on the write is served right after it
          if (pend_q || tick) begin
            state_d       = RD_ADDR;
            ram_address_d = scan_addr_q;
            pend_d        = 1'b0;
          end
        end
`endif
      end
      RD_ADDR: state_d = RD_CAP;
      RD_CAP: begin
        state_d   = RD_DONE;
        rd_addr_d = ram_address_q;
        rd_data_d = ram_q;
      end
      RD_DONE: begin
        state_d    = IDLE;
        rd_valid_d = 1'b1;
`ifdef RAM_AUTOSCAN_EN
        // reads are only launched from IDLE when not scanning, so while
        // scanning this was a scan read
        if (scanning_q) begin
          state_d     = SCAN_IDLE;
          scan_addr_d = scan_addr_q + ADDR_W'(1);
        end
`endif
      end
      CLEAR: begin
        ram_address_d = ram_address_q + ADDR_W'(1);
        ram_data_d    = '0;
        if (ram_address_q == {ADDR_W{1'b1}}) state_d = IDLE;
        else                                 ram_wren_d = 1'b1;
      end
`ifdef RAM_AUTOSCAN_EN
      SCAN_IDLE: begin
        if (accept && cmd_op == OP_WRITE) begin
          state_d       = WRITE;
          ram_address_d = cmd_addr;
          ram_data_d    = cmd_data;
          ram_wren_d    = 1'b1;
        end else if (accept && cmd_op == OP_SCAN) begin
          state_d    = IDLE;
          scanning_d = 1'b0;
          pend_d     = 1'b0;
        end else if (pend_q || tick) begin
          // read/clear accepted here fall through as no-ops
          state_d       = RD_ADDR;
          ram_address_d = scan_addr_q;
          pend_d        = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // controller state and output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_addr_q     <= '0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      rd_valid_q    <= rd_valid_d;
      rd_addr_q     <= rd_addr_d;
      rd_data_q     <= rd_data_d;
    end
  end

`ifdef RAM_AUTOSCAN_EN
  // scan enable, pending tick and scan address registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      scanning_q  <= 1'b0;
      pend_q      <= 1'b0;
      scan_addr_q <= '0;
    end else begin
      scanning_q  <= scanning_d;
      pend_q      <= pend_d;
      scan_addr_q <= scan_addr_d;
    end
  end

  assign scanning = scanning_q;
`else
  assign scanning = 1'b0;
`endif

  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign rd_valid    = rd_valid_q;
  assign rd_addr     = rd_addr_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed bench with a behavioural 32x4 RAM and a
// read-result scoreboard (expected addr/data/cycle queued at issue time).
module tb_ram_access_ctrl;

  localparam int AW = 5;
  localparam int DW = 4;
  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_SCN = 2'b11;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          scanning;

  ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SCAN_DIV(4)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q),
    .rd_valid    (rd_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .scanning    (scanning)
  );

  always #5 clock = ~clock;

  // RAM: registered address/data/wren, unregistered q
  logic [DW-1:0] mem [32];
  logic [AW-1:0] addr_r;
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    addr_r <= ram_address;
  end
  assign ram_q = mem[addr_r];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int errors = 0;
  int rdv_cnt = 0;
  logic [DW-1:0] model [32];

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            c;   // expected cyc at rd_valid, -1 = don't care
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // read-result monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (resetn === 1'b1 && rd_valid === 1'b1) begin
        rdv_cnt++;
        if (sb.size() == 0) begin
          check("rd_unexpected", 32'(rd_valid), 32'(0));
        end else begin
          e = sb.pop_front();
          check("rd_addr", 32'(rd_addr), 32'(e.a));
          check("rd_data", 32'(rd_data), 32'(e.d));
          if (e.c >= 0) check("rd_latency", 32'(cyc), 32'(e.c));
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // present a command, hold until accepted; returns at the negedge after
  // the accept edge. acc = cycle count just before the accept edge.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int acc);
    int n;
    n = 0;
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) check("cmd_accept_timeout", 32'(cmd_ready), 32'(1));
    acc = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc);
    issue(OP_WR, a, d, acc);
    model[a] = d;
    check("wr_pins", 32'({ram_wren, ram_address, ram_data}), 32'({1'b1, a, d}));
  endtask

  task automatic rd(input logic [AW-1:0] a);
    int acc;
    issue(OP_RD, a, '0, acc);
    sb.push_back('{a: a, d: model[a], c: acc + 4});
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'(0));
      sb.delete();
    end
  endtask

  task automatic fill();
    int acc;
    for (int i = 0; i < 32; i++) wr(5'(i), 4'(i), acc);
  endtask

  initial begin
    int acc;
    int r0;
    // reset values
    repeat (3) step();
    check("rst_outs", 32'({cmd_ready, ram_wren, rd_valid, scanning}), 32'(4'b1000));
    check("rst_regs", 32'({ram_address, ram_data, rd_addr, rd_data}), 32'(0));
    resetn = 1'b1;
    step();

    // single write then read-back
    wr(5'd5, 4'hA, acc);
    step();
    check("wr_one_cycle", 32'(ram_wren), 32'(0));
    rd(5'd5);
    drain(20);
    step();
    check("rd_pulse_end", 32'(rd_valid), 32'(0));
    check("rd_held", 32'({rd_addr, rd_data}), 32'({5'd5, 4'hA}));

    // fill, spot reads, full clear
    fill();
    rd(5'd17);
    rd(5'd31);
    drain(20);
    issue(OP_CLR, '0, '0, acc);
    for (int i = 0; i < 32; i++) begin
      check("clr_cycle", 32'({cmd_ready, ram_wren, ram_address, ram_data}),
            32'({1'b0, 1'b1, 5'(i), 4'h0}));
      step();
    end
    check("clr_done", 32'({cmd_ready, ram_wren}), 32'(2'b10));
    for (int i = 0; i < 32; i++) model[i] = '0;
    rd(5'd31);
    rd(5'd5);
    drain(20);

    // reset in the middle of a clear sweep
    fill();
    issue(OP_CLR, '0, '0, acc);
    repeat (10) step();
    check("clr_at_10", 32'({ram_wren, ram_address}), 32'({1'b1, 5'd10}));
    resetn = 1'b0;
    #1;
    check("async_rst", 32'({cmd_ready, ram_wren, rd_valid, scanning, ram_address, rd_addr}),
          32'({4'b1000, 5'd0, 5'd0}));
    for (int i = 0; i < 10; i++) model[i] = '0;
    step();
    step();
    resetn = 1'b1;
    step();
    rd(5'd9);
    rd(5'd10);
    rd(5'd20);
    rd(5'd31);
    drain(20);

`ifdef RAM_AUTOSCAN_EN
    // scan 0..29, stop, then resume from 30 across the wrap
    issue(OP_SCN, '0, '0, acc);
    check("scan_on", 32'({scanning, cmd_ready}), 32'(2'b11));
    for (int i = 0; i < 30; i++) sb.push_back('{a: 5'(i), d: model[i], c: -1});
    drain(200);
    issue(OP_SCN, '0, '0, acc);
    check("scan_off", 32'(scanning), 32'(0));
    repeat (5) step();
    issue(OP_SCN, '0, '0, acc);
    for (int i = 30; i < 34; i++) sb.push_back('{a: 5'(i % 32), d: model[i % 32], c: -1});
    drain(100);
    issue(OP_SCN, '0, '0, acc);
    check("scan_off2", 32'(scanning), 32'(0));
    r0 = rdv_cnt;
    repeat (20) step();
    check("no_pulses_after_stop", 32'(rdv_cnt), 32'(r0));

    // write landing on a divider tick defers the scan read by one cycle
    issue(OP_SCN, '0, '0, acc);
    sb.push_back('{a: 5'd2, d: model[2], c: -1});
    drain(50);
    wr(5'd2, 4'h7, acc);
    sb.push_back('{a: 5'd3, d: model[3], c: acc + 5});
    for (int i = 4; i < 35; i++) sb.push_back('{a: 5'(i % 32), d: model[i % 32], c: -1});
    drain(300);
    issue(OP_SCN, '0, '0, acc);
    check("scan_off3", 32'(scanning), 32'(0));
`else
    // op 11 is a one-cycle no-op without the scan feature
    r0 = rdv_cnt;
    issue(OP_SCN, '0, '0, acc);
    check("scan_noop", 32'({cmd_ready, scanning, ram_wren}), 32'(3'b100));
    repeat (20) step();
    check("scan_noop_quiet", 32'(rdv_cnt), 32'(r0));
    wr(5'd2, 4'h7, acc);
    rd(5'd2);
    drain(20);
`endif

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
